// File: rtl/conv_fifo_pkg.sv
// Shared cacheline type for the output-FIFO slice.
package conv_fifo_pkg;
    localparam int CACHELINE_W = 512;
    typedef logic [CACHELINE_W-1:0] cacheline_t;
endpackage

// File: rtl/cacheline_fifo_mem.sv
// DEPTH x cacheline storage: synchronous write, asynchronous (combinational) read.
module cacheline_fifo_mem
    import conv_fifo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  cacheline_t    wdata,
    input  logic [AW-1:0] raddr,
    output cacheline_t    rdata
);

    cacheline_t mem_q [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign rdata = mem_q[raddr];

endmodule

// File: rtl/cacheline_out_fifo.sv
// First-word-fall-through cacheline FIFO with early-full slack for a one-cycle-lag producer.
// Optional CACHELINE_OUT_FIFO_OVF_EN adds sticky overflow and a saturating drop counter.
module cacheline_out_fifo
    import conv_fifo_pkg::*;
#(
    parameter int DEPTH = 64,
    parameter int SLACK = 2
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     wr_valid,
    input  cacheline_t               wr_data,
    output logic                     full,
    input  logic                     rd_ready,
    output logic                     rd_valid,
    output cacheline_t               rd_data,
    output logic [$clog2(DEPTH):0]   count
`ifdef CACHELINE_OUT_FIFO_OVF_EN
    ,
    output logic                     overflow,
    output logic [31:0]              drop_count
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
    localparam logic [CW-1:0] FULL_TH_C = CW'(DEPTH - SLACK);

    logic [CW-1:0] count_q, count_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic          push, pop;

    assign rd_valid = (count_q != '0);
    assign pop      = rd_valid & rd_ready;
    // A pop in the same cycle frees the slot, so a push at DEPTH is still accepted.
    assign push     = wr_valid & ((count_q < DEPTH_C) | pop);
    assign full     = (count_q >= FULL_TH_C);
    assign count    = count_q;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        if (push && !pop) begin
            count_d = count_q + CW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    cacheline_fifo_mem #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push & ~reset),
        .waddr (wr_ptr_q),
        .wdata (wr_data),
        .raddr (rd_ptr_q),
        .rdata (rd_data)
    );

`ifdef CACHELINE_OUT_FIFO_OVF_EN
    logic        overflow_q, overflow_d;
    logic [31:0] drop_cnt_q, drop_cnt_d;
    logic        drop;

    assign drop = wr_valid & ~push;

    always_comb begin
        overflow_d = overflow_q | drop;
        drop_cnt_d = drop_cnt_q;
        if (drop && (drop_cnt_q != '1)) begin
            drop_cnt_d = drop_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    assign overflow   = overflow_q;
    assign drop_count = drop_cnt_q;
`endif

endmodule

// File: tb/tb_cacheline_out_fifo.sv
// Self-checking bench for cacheline_out_fifo (DEPTH=8, SLACK=2); covers CACHELINE_OUT_FIFO_OVF_EN when defined.
module tb_cacheline_out_fifo;
    import conv_fifo_pkg::*;

    localparam int DEPTH = 8;
    localparam int SLACK = 2;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        wr_valid = 1'b0;
    cacheline_t  wr_data = '0;
    logic        full;
    logic        rd_ready = 1'b0;
    logic        rd_valid;
    cacheline_t  rd_data;
    logic [3:0]  count;
`ifdef CACHELINE_OUT_FIFO_OVF_EN
    logic        overflow;
    logic [31:0] drop_count;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    cacheline_out_fifo #(
        .DEPTH (DEPTH),
        .SLACK (SLACK)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .wr_valid   (wr_valid),
        .wr_data    (wr_data),
        .full       (full),
        .rd_ready   (rd_ready),
        .rd_valid   (rd_valid),
        .rd_data    (rd_data),
        .count      (count)
`ifdef CACHELINE_OUT_FIFO_OVF_EN
        ,
        .overflow   (overflow),
        .drop_count (drop_count)
`endif
    );

    typedef struct {
        logic       rst;
        logic       wv;
        cacheline_t wd;
        logic       rr;
        int         ecount;
        logic       efull;
        logic       evld;
        logic       chkd;
        cacheline_t ed;
        logic       eovf;
        int         edrops;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic rst, logic wv, int wd, logic rr, int ecount,
                                logic efull, logic evld, logic chkd, int ed,
                                logic eovf, int edrops);
        vec_t v;
        v.rst = rst; v.wv = wv; v.wd = cacheline_t'(wd); v.rr = rr;
        v.ecount = ecount; v.efull = efull; v.evld = evld; v.chkd = chkd;
        v.ed = cacheline_t'(ed); v.eovf = eovf; v.edrops = edrops;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic cacheline_t rand_line();
        cacheline_t l;
        for (int w = 0; w < 16; w++) begin
            l[w*32 +: 32] = $urandom;
        end
        return l;
    endfunction

    initial begin
        cacheline_t model[$];
        cacheline_t exp_head;
        logic       lag_full;
        logic       exp_pop;
        int         mism;
        int         drops;

        // Reset, then fill 1..6 (full at 6), 7, 8, drop 9.
        vecs.push_back(mk(1, 0, 0,   0, 0, 0, 0, 0, 0,   0, 0));
        vecs.push_back(mk(0, 1, 1,   0, 1, 0, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 2,   0, 2, 0, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 3,   0, 3, 0, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 4,   0, 4, 0, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 5,   0, 5, 0, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 6,   0, 6, 1, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 7,   0, 7, 1, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 8,   0, 8, 1, 1, 1, 1,   0, 0));
        vecs.push_back(mk(0, 1, 9,   0, 8, 1, 1, 1, 1,   1, 1));
        // Push and pop together at DEPTH: count holds at 8.
        vecs.push_back(mk(0, 1, 'hA, 1, 8, 1, 1, 1, 2,   1, 1));
        vecs.push_back(mk(0, 1, 'hB, 1, 8, 1, 1, 1, 3,   1, 1));
        vecs.push_back(mk(0, 1, 'hC, 1, 8, 1, 1, 1, 4,   1, 1));
        // Drain in order: 4,5,6,7,8,A,B,C.
        vecs.push_back(mk(0, 0, 0,   1, 7, 1, 1, 1, 5,   1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 6, 1, 1, 1, 6,   1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 5, 0, 1, 1, 7,   1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 4, 0, 1, 1, 8,   1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 3, 0, 1, 1, 'hA, 1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 2, 0, 1, 1, 'hB, 1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 1, 0, 1, 1, 'hC, 1, 1));
        vecs.push_back(mk(0, 0, 0,   1, 0, 0, 0, 0, 0,   1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset    = vecs[i].rst;
            wr_valid = vecs[i].wv;
            wr_data  = vecs[i].wd;
            rd_ready = vecs[i].rr;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d count", i), 512'(count), 512'(vecs[i].ecount));
            chk($sformatf("v%0d full", i), 512'(full), 512'(vecs[i].efull));
            chk($sformatf("v%0d rd_valid", i), 512'(rd_valid), 512'(vecs[i].evld));
            if (vecs[i].chkd) begin
                chk($sformatf("v%0d rd_data", i), rd_data, vecs[i].ed);
            end
`ifdef CACHELINE_OUT_FIFO_OVF_EN
            chk($sformatf("v%0d overflow", i), 512'(overflow), 512'(vecs[i].eovf));
            chk($sformatf("v%0d drop_count", i), 512'(drop_count), 512'(vecs[i].edrops));
`endif
        end

        // Empty FIFO: no bypass of wr_data, one-cycle push-to-valid latency.
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b1; wr_data = cacheline_t'(512'hA5); rd_ready = 1'b1;
        #1;
        chk("bypass rd_valid", 512'(rd_valid), 512'(0));
        @(posedge clk); #1;
        chk("fwft rd_valid", 512'(rd_valid), 512'(1));
        chk("fwft rd_data", rd_data, 512'hA5);
        chk("fwft count", 512'(count), 512'(1));
        @(negedge clk);
        wr_valid = 1'b0;
        @(posedge clk); #1;
        chk("fwft drained count", 512'(count), 512'(0));
        chk("fwft drained rd_valid", 512'(rd_valid), 512'(0));

        // Fill to 5, then reset with a same-cycle push.
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            wr_valid = 1'b1; wr_data = cacheline_t'(512'h100 + i); rd_ready = 1'b0;
        end
        @(posedge clk); #1;
        chk("pre-reset count", 512'(count), 512'(5));
`ifdef CACHELINE_OUT_FIFO_OVF_EN
        chk("pre-reset overflow", 512'(overflow), 512'(1));
`endif
        @(negedge clk);
        reset = 1'b1; wr_valid = 1'b1; wr_data = cacheline_t'(512'hBAD);
        @(posedge clk); #1;
        chk("mid reset count", 512'(count), 512'(0));
        chk("mid reset rd_valid", 512'(rd_valid), 512'(0));
        chk("mid reset full", 512'(full), 512'(0));
`ifdef CACHELINE_OUT_FIFO_OVF_EN
        chk("mid reset overflow", 512'(overflow), 512'(0));
        chk("mid reset drop_count", 512'(drop_count), 512'(0));
`endif
        @(negedge clk);
        reset = 1'b0; wr_valid = 1'b0;

        // Random traffic: producer sees full one cycle late; slack must absorb it.
        mism = 0;
        drops = 0;
        lag_full = full;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk);
            rd_ready = ($urandom_range(0, 1) == 1);
            wr_valid = !lag_full && ($urandom_range(0, 3) != 0);
            wr_data  = rand_line();
            lag_full = full;
            #1;
            if (rd_valid !== (model.size() != 0)) begin
                if (mism == 0) $display("FAIL rand rd_valid at cycle %0d: got %0b expected %0b", c, rd_valid, model.size() != 0);
                mism++;
            end else if (model.size() != 0) begin
                exp_head = model[0];
                if (rd_data !== exp_head) begin
                    if (mism == 0) $display("FAIL rand rd_data at cycle %0d: got %0h expected %0h", c, rd_data, exp_head);
                    mism++;
                end
            end
            exp_pop = (model.size() != 0) && rd_ready;
            if (exp_pop) void'(model.pop_front());
            if (wr_valid) begin
                if ((model.size() < DEPTH) || exp_pop) model.push_back(wr_data);
                else drops++;
            end
        end
        @(posedge clk); #1;
        chk("rand scoreboard mismatches", 512'(mism), 512'(0));
        chk("rand model drops", 512'(drops), 512'(0));
        chk("rand final count", 512'(count), 512'(model.size()));
`ifdef CACHELINE_OUT_FIFO_OVF_EN
        chk("rand overflow", 512'(overflow), 512'(0));
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/cacheline_out_fifo.md
CACHELINE_OUT_FIFO -- requirements
Module: cacheline_out_fifo

Interface
REQ-001 SHALL have parameter DEPTH, default 64, number of 512-bit entries; power of two, at least 4.
REQ-002 SHALL have parameter SLACK, default 2, free entries still available when full asserts; 1 <= SLACK < DEPTH.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic on posedge.
REQ-004 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-005 SHALL have port wr_valid, input, 1, producer output_valid; push request.
REQ-006 SHALL have port wr_data, input, 512, producer cacheline_out.
REQ-007 SHALL have port full, output, 1, early-full; drives producer output_fifo_full.
REQ-008 SHALL have port rd_ready, input, 1, downstream host-write interface can accept.
REQ-009 SHALL have port rd_valid, output, 1, head entry present.
REQ-010 SHALL have port rd_data, output, 512, head entry, first-word-fall-through.
REQ-011 SHALL have port count, output, $clog2(DEPTH)+1, current occupancy.

Function
REQ-012 SHALL register count, wr_ptr and rd_ptr; pointers SHALL wrap modulo DEPTH.
REQ-013 SHALL define pop = rd_valid & rd_ready.
REQ-014 SHALL define push = wr_valid & (count < DEPTH | pop); a push with the FIFO at DEPTH and no pop is dropped.
REQ-015 SHALL drive full = (count >= DEPTH-SLACK) combinationally from registered count.
- Covers the producer's one-cycle gap between sampling ~full and asserting output_valid.
REQ-016 SHALL drive rd_valid = (count != 0) and rd_data = mem[rd_ptr].
- Push-to-rd_valid latency: one cycle.
REQ-017 SHALL update count by +1 on push only, -1 on pop only, unchanged on both or neither.
REQ-018 On simultaneous push and pop at count==DEPTH, SHALL accept both; count stays DEPTH.
REQ-019 With count==0, SHALL not present wr_data to rd_data in the same cycle (no bypass).
REQ-020 SHALL preserve entry order exactly, with no duplication or loss except dropped pushes (REQ-014).

Reset
REQ-021 Reset SHALL force count=0, wr_ptr=0, rd_ptr=0, rd_valid=0 and full=0 on the next edge.
- Storage is not cleared.
REQ-022 Reset mid-operation SHALL discard all entries, with reset taking priority over a same-cycle push or pop.

Configuration
REQ-023 Macro CACHELINE_OUT_FIFO_OVF_EN defined SHALL add output overflow (1, sticky):
- set on any dropped push;
- cleared only by reset.
REQ-024 Same macro SHALL add output drop_count (32, saturating): number of dropped pushes.
REQ-025 Macro undefined: SHALL omit both ports and their logic; all other behaviour identical.

Structure
REQ-026 Package conv_fifo_pkg SHALL hold:
- CACHELINE_W=512;
- typedef cacheline_t (logic [511:0]).
REQ-027 Storage SHALL be one sub-module cacheline_fifo_mem: DEPTH x 512, synchronous write, asynchronous read.
- Pointer, count and flag logic stays in cacheline_out_fifo.

Verification
REQ-028 DEPTH=8, SLACK=2, rd_ready=0; push 6 lines 0x1..0x6.
- full=1 after the 6th push; count=6.
REQ-029 Continue from REQ-028: push 0x7, 0x8, 0x9 with rd_ready still 0.
- 0x9 dropped; count=8.
- With CACHELINE_OUT_FIFO_OVF_EN: overflow=1, drop_count=1.
REQ-030 count=8, wr_valid=1 and rd_ready=1 for 3 cycles.
- Pops 0x1..0x3, accepts 3 new lines; count=8; overflow unchanged.
REQ-031 Empty FIFO; push 0xA5 with rd_ready=1.
- rd_valid=0 that cycle; next cycle rd_valid=1, rd_data=0xA5; count back to 0 after pop.
REQ-032 Fill to 5 entries, then assert reset for one cycle with wr_valid=1.
- Next cycle count=0, rd_valid=0, full=0; overflow cleared.
REQ-033 Random wr_valid/rd_ready over 10000 cycles, producer honouring full with a one-cycle lag.
- Scoreboard order matches; zero drops.
